// File: rtl/fppu_pkg.sv
// Shared constants and slot state encoding for the dual-core FPU dispatcher.
package fppu_pkg;
    localparam int FP_W  = 32;
    localparam int NCORE = 2;
    localparam logic [FP_W-1:0] QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } slot_state_t;
endpackage

// File: rtl/fppu_slot.sv
// One dispatch slot per FPU core: start pulse, operand hold, finish/timeout
// capture and result holding until the retire pointer pops it.
module fppu_slot
    import fppu_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_issue,
    input  logic            i_pop,
    input  logic            i_fi,
    input  logic [FP_W-1:0] i_g,
    input  logic [FP_W-1:0] i_a,
    input  logic [FP_W-1:0] i_b,
    input  logic [FP_W-1:0] i_c,
    input  logic [FP_W-1:0] i_d,
    output logic [1:0]      o_state,
    output logic            o_en,
    output logic [FP_W-1:0] o_a,
    output logic [FP_W-1:0] o_b,
    output logic [FP_W-1:0] o_c,
    output logic [FP_W-1:0] o_d,
    output logic [FP_W-1:0] o_g,
    output logic            o_err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    slot_state_t     r_state;
    slot_state_t     w_state_next;
    logic [TW-1:0]   r_timer;
    logic            r_en;
    logic [FP_W-1:0] r_a, r_b, r_c, r_d;
    logic [FP_W-1:0] r_g;
    logic            r_err;
    logic            w_start;
    logic            w_fi_ok;
    logic            w_expired;

    assign w_start   = i_issue && (r_state == S_IDLE);
    // Timer is 0 during the start-pulse cycle, so a finish there is not a result.
    assign w_fi_ok   = i_fi && (r_timer != '0);
    assign w_expired = (r_timer == TMAX);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_next = S_RUN;
            S_RUN:   if (w_fi_ok || w_expired) w_state_next = S_DONE;
            S_DONE:  if (i_pop) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_en    <= 1'b0;
            r_timer <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_g     <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_en    <= w_start;
            if (w_start) begin
                r_a     <= i_a;
                r_b     <= i_b;
                r_c     <= i_c;
                r_d     <= i_d;
                r_timer <= '0;
            end else if ((r_state == S_RUN) && !w_expired) begin
                r_timer <= r_timer + TW'(1);
            end
            // A finish in the last window cycle beats the timeout.
            if (r_state == S_RUN) begin
                if (w_fi_ok) begin
                    r_g   <= i_g;
                    r_err <= 1'b0;
                end else if (w_expired) begin
                    r_g   <= QNAN;
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign o_state = r_state;
    assign o_en    = r_en;
    assign o_a     = r_a;
    assign o_b     = r_b;
    assign o_c     = r_c;
    assign o_d     = r_d;
    assign o_g     = r_g;
    assign o_err   = r_err;
endmodule

// File: rtl/fppu_dispatch.sv
// Round-robin job dispatcher for a pair of FPU cores; results retire in
// issue order because issue and retire pointers walk the same two slots.
module fppu_dispatch
    import fppu_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FP_W-1:0]       in_a,
    input  logic [FP_W-1:0]       in_b,
    input  logic [FP_W-1:0]       in_c,
    input  logic [FP_W-1:0]       in_d,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FP_W-1:0]       out_g,
    output logic                  out_err,
    output logic [NCORE-1:0]      core_en,
    output logic [NCORE*FP_W-1:0] core_a,
    output logic [NCORE*FP_W-1:0] core_b,
    output logic [NCORE*FP_W-1:0] core_c,
    output logic [NCORE*FP_W-1:0] core_d,
    input  logic [NCORE-1:0]      core_fi,
    input  logic [NCORE*FP_W-1:0] core_g
);
    logic            r_ip;
    logic            r_rp;
    logic            w_accept;
    logic            w_pop;
    logic [1:0]      w_state [NCORE];
    logic [FP_W-1:0] w_g     [NCORE];
    logic [NCORE-1:0] w_err;

    assign in_ready  = (w_state[r_ip] == S_IDLE);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (w_state[r_rp] == S_DONE);
    assign out_g     = w_g[r_rp];
    assign out_err   = w_err[r_rp];
    assign w_pop     = out_valid && out_ready;

    for (genvar gi = 0; gi < NCORE; gi++) begin : g_slot
        fppu_slot #(
            .TIMEOUT(TIMEOUT)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .i_issue (w_accept && (r_ip == 1'(gi))),
            .i_pop   (w_pop && (r_rp == 1'(gi))),
            .i_fi    (core_fi[gi]),
            .i_g     (core_g[gi*FP_W +: FP_W]),
            .i_a     (in_a),
            .i_b     (in_b),
            .i_c     (in_c),
            .i_d     (in_d),
            .o_state (w_state[gi]),
            .o_en    (core_en[gi]),
            .o_a     (core_a[gi*FP_W +: FP_W]),
            .o_b     (core_b[gi*FP_W +: FP_W]),
            .o_c     (core_c[gi*FP_W +: FP_W]),
            .o_d     (core_d[gi*FP_W +: FP_W]),
            .o_g     (w_g[gi]),
            .o_err   (w_err[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ip <= 1'b0;
            r_rp <= 1'b0;
        end else begin
            if (w_accept) r_ip <= ~r_ip;
            if (w_pop)    r_rp <= ~r_rp;
        end
    end
endmodule

// File: tb/tb_fppu_dispatch.sv
// Scoreboard bench for fppu_dispatch: directed scenarios plus random jobs,
// with per-core behavioural FPU models and an in-order result monitor.
module tb_fppu_dispatch;
    localparam int TO = 16;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef struct {
        logic [31:0] a, b, c, d, g;
        int          dly;
    } job_t;
    typedef struct {
        logic [31:0] g;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0;
    wire         in_ready, out_valid, out_err;
    wire  [31:0] out_g;
    wire  [1:0]  core_en, core_fi;
    wire  [63:0] core_a, core_b, core_c, core_d, core_g;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   n_issued = 0;
    int   epoch = 0;
    logic done = 1'b0;
    exp_t exp_q[$];
    job_t cq[2][$];

    fppu_dispatch #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_g(out_g), .out_err(out_err),
        .core_en(core_en), .core_a(core_a), .core_b(core_b),
        .core_c(core_c), .core_d(core_d),
        .core_fi(core_fi), .core_g(core_g)
    );

    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Offer one job; record it for the core model and the result scoreboard once accepted.
    task automatic send_job(input logic [31:0] a, b, c, d, g, input int dly, output int t);
        int   n;
        job_t j;
        exp_t e;
        @(negedge clk);
        in_a = a; in_b = b; in_c = c; in_d = d; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL accept_wait: in_ready=0 after %0d cycles, required 1", n);
            in_valid = 1'b0;
            t = -1;
            return;
        end
        t = cyc;
        @(posedge clk);
        j.a = a; j.b = b; j.c = c; j.d = d; j.g = g; j.dly = dly;
        cq[n_issued % 2].push_back(j);
        n_issued++;
        e.g   = (dly <= TO) ? g : QNAN;
        e.err = (dly > TO);
        exp_q.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_ov(output int v);
        int n = 0;
        v = -1;
        while (n < 200) begin
            @(negedge clk);
            if (out_valid) begin
                v = cyc;
                break;
            end
            n++;
        end
        if (v < 0) begin
            tests++; fails++;
            $display("FAIL out_valid_wait: out_valid=0 for 200 cycles, required 1");
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        cq[0].delete();
        cq[1].delete();
        n_issued = 0;
        epoch++;
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_g", 64'(out_g), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        chk("rst_core_en", 64'(core_en), 64'd0);
        chk("rst_core_ops", 64'(|{core_a, core_b, core_c, core_d}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Behavioural FPU cores: answer each start pulse after the job's chosen delay.
    for (genvar gi = 0; gi < 2; gi++) begin : g_core
        logic        fi_l = 1'b0;
        logic [31:0] g_l = '0;
        assign core_fi[gi] = fi_l;
        assign core_g[32*gi +: 32] = g_l;

        initial begin
            job_t j;
            int   ep;
            forever begin
                @(negedge clk);
                if (rst && core_en[gi]) begin
                    tests++;
                    if (cq[gi].size() == 0) begin
                        fails++;
                        $display("FAIL core%0d_en: start pulse with no job routed to this core", gi);
                    end else begin
                        j = cq[gi].pop_front();
                        ep = epoch;
                        if ({core_a[32*gi +: 32], core_b[32*gi +: 32], core_c[32*gi +: 32], core_d[32*gi +: 32]}
                            !== {j.a, j.b, j.c, j.d}) begin
                            fails++;
                            $display("FAIL core%0d_ops: got %h %h %h %h required %h %h %h %h", gi,
                                     core_a[32*gi +: 32], core_b[32*gi +: 32], core_c[32*gi +: 32],
                                     core_d[32*gi +: 32], j.a, j.b, j.c, j.d);
                        end
                        for (int k = 0; k < j.dly; k++) begin
                            @(negedge clk);
                            if (rst && core_en[gi] && ep == epoch) begin
                                tests++; fails++;
                                $display("FAIL core%0d_en_busy: en=1 while job in flight, required 0", gi);
                            end
                        end
                        if (ep == epoch && j.dly <= TO) begin
                            tests++;
                            if ({core_a[32*gi +: 32], core_b[32*gi +: 32], core_c[32*gi +: 32], core_d[32*gi +: 32]}
                                !== {j.a, j.b, j.c, j.d}) begin
                                fails++;
                                $display("FAIL core%0d_hold: operands changed during run, got a=%h required a=%h",
                                         gi, core_a[32*gi +: 32], j.a);
                            end
                        end
                        fi_l = 1'b1;
                        g_l  = j.g;
                        @(negedge clk);
                        fi_l = 1'b0;
                        g_l  = $urandom;
                    end
                end
            end
        end
    end

    // Result monitor: in-order compare on every pop, stability check while stalled.
    initial begin
        logic        stall;
        logic [31:0] pg;
        logic        perr;
        exp_t        e;
        stall = 1'b0;
        pg = '0;
        perr = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    tests++;
                    if (!out_valid || out_g !== pg || out_err !== perr) begin
                        fails++;
                        $display("FAIL out_hold: got v=%b g=%h err=%b required v=1 g=%h err=%b",
                                 out_valid, out_g, out_err, pg, perr);
                    end
                end
                if (out_valid && out_ready) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL result_extra: got g=%h err=%b required no result", out_g, out_err);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_g !== e.g || out_err !== e.err) begin
                            fails++;
                            $display("FAIL result: got g=%h err=%b required g=%h err=%b",
                                     out_g, out_err, e.g, e.err);
                        end
                    end
                    stall = 1'b0;
                end else if (out_valid) begin
                    stall = 1'b1;
                    pg = out_g;
                    perr = out_err;
                end else begin
                    stall = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t1, t2, v, p, cnt;
        logic [31:0] gr;
        out_ready = 1'b1;
        do_reset();

        // Single job on core0
        send_job(32'h3F800000, 32'h40000000, 32'h0, 32'h0, 32'h40400000, 5, t);
        @(negedge clk);
        chk("single_en", 64'(core_en), 64'h1);
        wait_ov(v);
        chk("single_latency", 64'(v), 64'(t + 7));
        chk("single_g", 64'(out_g), 64'h40400000);
        repeat (3) @(negedge clk);

        // Out-of-order finish: core1 done first, result still waits for core0
        do_reset();
        send_job($urandom, $urandom, $urandom, $urandom, $urandom, 10, t);
        send_job($urandom, $urandom, $urandom, $urandom, $urandom, 2, t1);
        chk("ooo_issue", 64'(t1), 64'(t + 1));
        wait_ov(v);
        chk("ooo_first_valid", 64'(v), 64'(t + 12));
        wait_drain();

        // Backpressure: two slots fill, third waits for the first pop
        do_reset();
        out_ready = 1'b0;
        send_job(32'h1, 32'h2, 32'h3, 32'h4, 32'hA0A0A0A0, 3, t);
        send_job(32'h5, 32'h6, 32'h7, 32'h8, 32'hB0B0B0B0, 3, t1);
        p = 0;
        fork
            send_job(32'h9, 32'hA, 32'hB, 32'hC, 32'hC0C0C0C0, 3, t2);
            begin
                cnt = 0;
                repeat (8) begin
                    @(negedge clk);
                    if (in_ready) cnt++;
                end
                chk("bp_in_ready_low", 64'(cnt), 64'd0);
                @(posedge clk);
                #1 out_ready = 1'b1;
                p = cyc;
            end
        join
        chk("bp_issue_after_pop", 64'(t2), 64'(p + 1));
        @(negedge clk);
        chk("bp_en_core0", 64'(core_en), 64'h1);
        wait_drain();

        // Timeout with a late finish that must be ignored
        do_reset();
        send_job($urandom, $urandom, $urandom, $urandom, $urandom, 20, t);
        wait_ov(v);
        chk("to_latency", 64'(v), 64'(t + 18));
        chk("to_err", 64'(out_err), 64'd1);
        chk("to_g", 64'(out_g), 64'(QNAN));
        cnt = 0;
        while (cyc < t + 26) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("to_late_fi_ignored", 64'(cnt), 64'd0);

        // Finish exactly in the last window cycle
        gr = $urandom;
        send_job($urandom, $urandom, $urandom, $urandom, gr, TO, t);
        wait_ov(v);
        chk("edge_latency", 64'(v), 64'(t + 18));
        chk("edge_err", 64'(out_err), 64'd0);
        chk("edge_g", 64'(out_g), 64'(gr));
        wait_drain();

        // Reset while both slots run
        do_reset();
        send_job($urandom, $urandom, $urandom, $urandom, $urandom, 15, t);
        send_job($urandom, $urandom, $urandom, $urandom, $urandom, 15, t1);
        repeat (3) @(negedge clk);
        do_reset();
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("rst_late_fi_ignored", 64'(cnt), 64'd0);
        send_job($urandom, $urandom, $urandom, $urandom, $urandom, 2, t);
        @(negedge clk);
        chk("rst_next_en_core0", 64'(core_en), 64'h1);
        wait_ov(v);
        chk("rst_next_latency", 64'(v), 64'(t + 4));
        wait_drain();

        // Random jobs with random backpressure
        do_reset();
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    int r, dly, tt;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    r = $urandom_range(0, 9);
                    dly = (r == 0) ? TO + 1 : (r == 1) ? TO : $urandom_range(1, 8);
                    send_job($urandom, $urandom, $urandom, $urandom, $urandom, dly, tt);
                end
                wait_drain();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
